// File: rtl/mips_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mips_bus_sequencer
// Purpose  : Drives a single-cycle Harvard MIPS core through one Avalon-MM
//            master port. Each instruction goes through FETCH, DECODE (settle),
//            an optional DATA transfer, and COMMIT (one-cycle clk_enable).
//            This block owns all bus handshaking and core stalling.
// Ports    : clk, reset (async, active-low)
//            core side  : cpu_active, instr_address, instr_readdata,
//                         data_address, data_read, data_write, data_writedata,
//                         data_byteenable, data_readdata, clk_enable
//            Avalon side: address, read, write, waitrequest, writedata,
//                         byteenable, readdata, bus_error
// Options  : MIPS_BUS_TIMEOUT_EN - when defined, a stalled transfer is
//            abandoned after TIMEOUT_CYCLES waitrequest cycles, bus_error is
//            set, and the block parks in IDLE until reset.
// Revision : 1.0 - initial release
// ============================================================================
module mips_bus_sequencer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int DEC_SETTLE     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_active,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_writedata,
    input  logic [3:0]  data_byteenable,
    output logic [31:0] data_readdata,
    output logic        clk_enable,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata,
    output logic        bus_error
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_FETCH  = 3'd1;
    localparam logic [2:0] c_DECODE = 3'd2;
    localparam logic [2:0] c_DATA   = 3'd3;
    localparam logic [2:0] c_COMMIT = 3'd4;

    // Decode counter counts down from DEC_SETTLE-1 to 0; the data request is
    // sampled on the cycle it reads zero.
    localparam logic [1:0] c_DEC_LOAD = 2'(DEC_SETTLE - 1);

    logic [2:0]  r_state;
    logic [1:0]  r_dec_cnt;
    logic [31:0] r_instr_readdata;
    logic [31:0] r_data_readdata;
    logic        r_clk_enable;
    logic [31:0] r_address;
    logic        r_read;
    logic        r_write;
    logic [31:0] r_writedata;
    logic [3:0]  r_byteenable;

    logic        w_timeout;
    logic        w_halted;
    logic [31:0] w_fetch_addr;

    assign w_fetch_addr = {instr_address[31:2], 2'b00};

`ifdef MIPS_BUS_TIMEOUT_EN
    localparam logic [15:0] c_TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_wait_cnt;
    logic        r_bus_error;
    logic        w_bus_state;

    assign w_bus_state = (r_state == c_FETCH) || (r_state == c_DATA);
    // Fires on the cycle that would be the TIMEOUT_CYCLES-th stalled cycle.
    assign w_timeout   = w_bus_state && waitrequest && (r_wait_cnt == c_TO_LAST);
    assign w_halted    = r_bus_error;
    assign bus_error   = r_bus_error;

    // The state can only change out of FETCH/DATA when waitrequest is low or
    // on timeout, so clearing whenever the stall condition is absent is the
    // same as clearing on every state change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt  <= 16'd0;
            r_bus_error <= 1'b0;
        end else begin
            if (w_bus_state && waitrequest && !w_timeout) begin
                r_wait_cnt <= r_wait_cnt + 16'd1;
            end else begin
                r_wait_cnt <= 16'd0;
            end
            if (w_timeout) begin
                r_bus_error <= 1'b1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign w_halted  = 1'b0;
    assign bus_error = 1'b0;
`endif

    // Address low bits are always forced to a word boundary.
    logic w_unused;
    assign w_unused = &{1'b0, instr_address[1:0], data_address[1:0], (TIMEOUT_CYCLES > 0)};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state          <= c_IDLE;
            r_dec_cnt        <= 2'd0;
            r_instr_readdata <= 32'd0;
            r_data_readdata  <= 32'd0;
            r_clk_enable     <= 1'b0;
            r_address        <= 32'd0;
            r_read           <= 1'b0;
            r_write          <= 1'b0;
            r_writedata      <= 32'd0;
            r_byteenable     <= 4'd0;
        end else begin
            r_clk_enable <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (cpu_active && !w_halted) begin
                        r_state      <= c_FETCH;
                        r_read       <= 1'b1;
                        r_address    <= w_fetch_addr;
                        r_byteenable <= 4'b1111;
                    end
                end
                c_FETCH: begin
                    if (w_timeout) begin
                        r_read  <= 1'b0;
                        r_state <= c_IDLE;
                    end else if (!waitrequest) begin
                        r_instr_readdata <= readdata;
                        r_read           <= 1'b0;
                        r_dec_cnt        <= c_DEC_LOAD;
                        r_state          <= c_DECODE;
                    end
                end
                c_DECODE: begin
                    if (r_dec_cnt != 2'd0) begin
                        r_dec_cnt <= r_dec_cnt - 2'd1;
                    end else if (data_read || data_write) begin
                        // A simultaneous load and store request performs only the load.
                        r_read       <= data_read;
                        r_write      <= data_write && !data_read;
                        r_address    <= {data_address[31:2], 2'b00};
                        r_byteenable <= data_byteenable;
                        r_writedata  <= data_writedata;
                        r_state      <= c_DATA;
                    end else begin
                        r_clk_enable <= 1'b1;
                        r_state      <= c_COMMIT;
                    end
                end
                c_DATA: begin
                    if (w_timeout) begin
                        r_read  <= 1'b0;
                        r_write <= 1'b0;
                        r_state <= c_IDLE;
                    end else if (!waitrequest) begin
                        if (r_read) begin
                            r_data_readdata <= readdata;
                        end
                        r_read       <= 1'b0;
                        r_write      <= 1'b0;
                        r_clk_enable <= 1'b1;
                        r_state      <= c_COMMIT;
                    end
                end
                c_COMMIT: begin
                    if (cpu_active) begin
                        r_state      <= c_FETCH;
                        r_read       <= 1'b1;
                        r_address    <= w_fetch_addr;
                        r_byteenable <= 4'b1111;
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_read  <= 1'b0;
                    r_write <= 1'b0;
                end
            endcase
        end
    end

    assign instr_readdata = r_instr_readdata;
    assign data_readdata  = r_data_readdata;
    assign clk_enable     = r_clk_enable;
    assign address        = r_address;
    assign read           = r_read;
    assign write          = r_write;
    assign writedata      = r_writedata;
    assign byteenable     = r_byteenable;

endmodule
`default_nettype wire

// File: tb/tb_mips_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_bus_sequencer
// Purpose  : Self-checking bench for mips_bus_sequencer. A table of
//            instruction records drives the core side; a bench-side Avalon
//            slave inserts wait states and supplies read data; expected bus
//            transfers and commit results are queued when each record is
//            driven and compared when the DUT produces them.
// Options  : MIPS_BUS_TIMEOUT_EN - adds the stuck-waitrequest timeout sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_bus_sequencer;

    localparam int c_DEC = 1;
`ifdef MIPS_BUS_TIMEOUT_EN
    localparam int c_TO = 8;
`else
    localparam int c_TO = 255;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_active = 1'b0;
    logic [31:0] instr_address = 32'd0;
    logic [31:0] instr_readdata;
    logic [31:0] data_address = 32'd0;
    logic        data_read = 1'b0;
    logic        data_write = 1'b0;
    logic [31:0] data_writedata = 32'd0;
    logic [3:0]  data_byteenable = 4'd0;
    logic [31:0] data_readdata;
    logic        clk_enable;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic        waitrequest = 1'b0;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata = 32'd0;
    logic        bus_error;

    always #5 clk = ~clk;

    mips_bus_sequencer #(
        .TIMEOUT_CYCLES (c_TO),
        .DEC_SETTLE     (c_DEC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cpu_active      (cpu_active),
        .instr_address   (instr_address),
        .instr_readdata  (instr_readdata),
        .data_address    (data_address),
        .data_read       (data_read),
        .data_write      (data_write),
        .data_writedata  (data_writedata),
        .data_byteenable (data_byteenable),
        .data_readdata   (data_readdata),
        .clk_enable      (clk_enable),
        .address         (address),
        .read            (read),
        .write           (write),
        .waitrequest     (waitrequest),
        .writedata       (writedata),
        .byteenable      (byteenable),
        .readdata        (readdata),
        .bus_error       (bus_error)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] daddr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic        ld;
        logic        st;
        int          fw;
        int          dwait;
    } vec_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } xfer_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] dread;
    } commit_t;

    xfer_t   sb_q[$];
    commit_t cm_q[$];

    int n_vec  = 0;
    int n_fail = 0;

    // Slave configuration for the instruction currently in flight
    int          cur_fw = 0;
    int          cur_dw = 0;
    logic [31:0] cur_instr = 32'd0;
    logic [31:0] cur_rdata = 32'd0;
    bit          seen_fetch = 1'b0;
    logic [31:0] exp_dread = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- Avalon slave + scoreboard monitor ----------------
    int          wcnt = 0;
    bit          prev_wait = 1'b0;
    logic        prev_ce = 1'b0;
    logic [69:0] prev_bus = 70'd0;

    always @(negedge clk) begin
        xfer_t   ex;
        commit_t ec;
        int      wl;
        if (!reset) begin
            waitrequest = 1'b0;
            prev_wait   = 1'b0;
            prev_ce     = 1'b0;
            wcnt        = 0;
        end else begin
            if (read || write) begin
                chk("rd_wr_exclusive", 32'(read & write), 32'd0);
                if (prev_wait) begin
                    chk("bus_stable_hi", {30'd0, read, write}, {30'd0, prev_bus[69:68]});
                    chk("bus_stable_addr", address, prev_bus[67:36]);
                    chk("bus_stable_wd", writedata, prev_bus[35:4]);
                    chk("bus_stable_be", 32'(byteenable), 32'(prev_bus[3:0]));
                end
                prev_bus = {read, write, address, writedata, byteenable};
                wl = seen_fetch ? cur_dw : cur_fw;
                if (wcnt < wl) begin
                    waitrequest = 1'b1;
                    wcnt++;
                    prev_wait = 1'b1;
                end else begin
                    waitrequest = 1'b0;
                    readdata    = seen_fetch ? cur_rdata : cur_instr;
                    wcnt        = 0;
                    prev_wait   = 1'b0;
                    seen_fetch  = 1'b1;
                    if (sb_q.size() == 0) begin
                        chk("unexpected_xfer", 32'(1), 32'(0));
                    end else begin
                        ex = sb_q.pop_front();
                        chk("xfer_kind", {30'd0, read, write}, {30'd0, ex.rd, ex.wr});
                        chk("xfer_addr", address, ex.addr);
                        chk("xfer_be", 32'(byteenable), 32'(ex.be));
                        if (ex.wr) chk("xfer_wdata", writedata, ex.wdata);
                    end
                end
            end else begin
                waitrequest = 1'b0;
                readdata    = $urandom;
                prev_wait   = 1'b0;
                wcnt        = 0;
            end
            if (clk_enable) begin
                chk("ce_single_cycle", 32'(prev_ce), 32'd0);
                if (cm_q.size() == 0) begin
                    chk("unexpected_commit", 32'(1), 32'(0));
                end else begin
                    ec = cm_q.pop_front();
                    chk("commit_instr", instr_readdata, ec.instr);
                    chk("commit_dread", data_readdata, ec.dread);
                end
            end
            prev_ce = clk_enable;
        end
    end

    // ---------------- Instruction driver ----------------
    // Called right after a negedge; returns at the negedge where clk_enable is seen.
    task automatic run_vec(input vec_t v, input bit drop);
        xfer_t   x;
        commit_t c;
        int      cyc;
        int      expc;
        bit      done;
        instr_address   = v.pc;
        data_address    = v.daddr;
        data_read       = v.ld;
        data_write      = v.st;
        data_writedata  = v.wdata;
        data_byteenable = v.be;
        cur_fw          = v.fw;
        cur_dw          = v.dwait;
        cur_instr       = v.instr;
        cur_rdata       = v.rdata;
        seen_fetch      = 1'b0;
        cpu_active      = 1'b1;
        x.rd = 1'b1; x.wr = 1'b0; x.addr = {v.pc[31:2], 2'b00}; x.be = 4'hF; x.wdata = 32'd0;
        sb_q.push_back(x);
        expc = 2 + c_DEC + v.fw;
        if (v.ld || v.st) begin
            x.rd = v.ld; x.wr = !v.ld; x.addr = {v.daddr[31:2], 2'b00};
            x.be = v.be; x.wdata = v.wdata;
            sb_q.push_back(x);
            expc += 1 + v.dwait;
            if (v.ld) exp_dread = v.rdata;
        end
        c.instr = v.instr;
        c.dread = exp_dread;
        cm_q.push_back(c);
        cyc  = 0;
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (cyc > 0 || read) cyc++;
            if (drop && cyc == 3) cpu_active = 1'b0;
            if (clk_enable) done = 1'b1;
        end
        chk("instr_cycles", done ? 32'(cyc) : 32'hFFFF_FFFF, 32'(expc));
        if (!done) begin
            sb_q.delete();
            cm_q.delete();
        end
    endtask

    function automatic vec_t mk(input logic [31:0] pc, instr, daddr, wdata, rdata,
                                input logic [3:0] be, input logic ld, st,
                                input int fw, dwait);
        vec_t v;
        v.pc = pc; v.instr = instr; v.daddr = daddr; v.wdata = wdata; v.rdata = rdata;
        v.be = be; v.ld = ld; v.st = st; v.fw = fw; v.dwait = dwait;
        return v;
    endfunction

    vec_t vecs[7];

    initial begin
        int bus_cnt;
        int ce_cnt;
        vec_t hv;

        vecs[0] = mk(32'hBFC0_0000, 32'h2402_0005, 32'h0,         32'h0,         32'h0,         4'hF, 0, 0, 0, 0);
        vecs[1] = mk(32'hBFC0_0004, 32'h8C43_0000, 32'h0000_1003, 32'h0,         32'hDEAD_BEEF, 4'hF, 1, 0, 0, 3);
        vecs[2] = mk(32'hBFC0_0008, 32'hAC44_0000, 32'h0000_2000, 32'h1234_5678, 32'h0,         4'b0011, 0, 1, 0, 0);
        vecs[3] = mk(32'hBFC0_000C, 32'h8C45_0004, 32'h0000_3006, 32'h5555_5555, 32'hCAFE_F00D, 4'b1100, 1, 1, 0, 1);
        vecs[4] = mk(32'hBFC0_0012, 32'h0000_0000, 32'h0,         32'h0,         32'h0,         4'hF, 0, 0, 2, 0);
        vecs[5] = mk(32'hBFC0_0014, 32'hAC46_0008, 32'h0000_4001, 32'hA5A5_0F0F, 32'h0,         4'hF, 0, 1, 1, 2);
        vecs[6] = mk(32'hBFC0_0018, 32'h8047_0000, 32'h0000_5003, 32'h0,         32'h7766_5544, 4'b0001, 1, 0, 1, 0);

        // Reset state
        @(negedge clk);
        chk("rst_read", 32'(read), 32'd0);
        chk("rst_write", 32'(write), 32'd0);
        chk("rst_ce", 32'(clk_enable), 32'd0);
        chk("rst_addr", address, 32'd0);
        chk("rst_be", 32'(byteenable), 32'd0);
        chk("rst_instr", instr_readdata, 32'd0);
        chk("rst_dread", data_readdata, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_no_read", 32'(read), 32'd0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], 1'b0);

        // cpu_active falls during DATA: commit still happens, then no new fetch
        hv = mk(32'hBFC0_0020, 32'h8C48_0000, 32'h0000_6000, 32'h0, 32'h0BAD_F00D, 4'hF, 1, 0, 0, 3);
        run_vec(hv, 1'b1);
        bus_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (read || write) bus_cnt++;
        end
        chk("idle_after_drop", 32'(bus_cnt), 32'd0);

        // Restart from IDLE
        hv = mk(32'hBFC0_0024, 32'h2409_0001, 32'h0, 32'h0, 32'h0, 4'hF, 0, 0, 1, 0);
        run_vec(hv, 1'b0);

        // Reset asserted mid-FETCH while stalled
        cur_fw        = 1000;
        seen_fetch    = 1'b0;
        instr_address = 32'hBFC0_0040;
        data_read     = 1'b0;
        data_write    = 1'b0;
        repeat (3) @(negedge clk);
        chk("stalled_fetch_read", 32'(read), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst_read", 32'(read), 32'd0);
        chk("arst_write", 32'(write), 32'd0);
        chk("arst_addr", address, 32'd0);
        chk("arst_be", 32'(byteenable), 32'd0);
        chk("arst_wdata", writedata, 32'd0);
        chk("arst_instr", instr_readdata, 32'd0);
        chk("arst_dread", data_readdata, 32'd0);
        chk("arst_ce", 32'(clk_enable), 32'd0);
        cpu_active = 1'b0;
        sb_q.delete();
        cm_q.delete();
        exp_dread = 32'd0;
        cur_fw = 0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_vec(vecs[1], 1'b0);

`ifdef MIPS_BUS_TIMEOUT_EN
        // Stuck waitrequest: fetch abandoned after c_TO stalled cycles
        cpu_active = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cur_fw     = 1000;
        seen_fetch = 1'b0;
        cpu_active = 1'b1;
        bus_cnt = 0;
        ce_cnt  = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (read || write) bus_cnt++;
            if (clk_enable) ce_cnt++;
        end
        chk("to_read_cycles", 32'(bus_cnt), 32'(c_TO));
        chk("to_bus_error", 32'(bus_error), 32'd1);
        chk("to_no_commit", 32'(ce_cnt), 32'd0);
        chk("to_read_low", 32'(read), 32'd0);
        sb_q.delete();
        cm_q.delete();
        cpu_active = 1'b0;
        reset = 1'b0;
        #1;
        chk("to_err_cleared", 32'(bus_error), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        cur_fw = 0;
`else
        ce_cnt = 0;
        chk("bus_error_tied", 32'(bus_error), 32'(ce_cnt));
`endif

        @(negedge clk);
        chk("sb_drained", 32'(sb_q.size() + cm_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
